// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and op decode helpers for the iterative MDU
package mdu_pkg;
   typedef enum logic [1:0] {MDU_UMULL = 2'b00, MDU_SMULL = 2'b01, MDU_UDIV = 2'b10, MDU_SDIV = 2'b11} op_t;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   function automatic logic is_signed(op_t o);
      return o[0];
   endfunction
   function automatic logic is_div(op_t o);
      return o[1];
   endfunction
endpackage

// File: rtl/mdu_signfix.sv
// mdu_signfix: conditional two's-complement negate
module mdu_signfix #(
   parameter int W = 32
) (
   input  logic [W-1:0] x,
   input  logic         neg,
   output logic [W-1:0] y
);
   assign y = neg ? ~x + W'(1) : x;
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative shift-add multiply / restoring divide with start/busy/done handshake
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             kill,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi,
   output logic             div_zero,
   output logic [1:0]       flags
);
   localparam int CNTW = $clog2(WIDTH + 1);
   state_t st;
   op_t opr;
   logic [2*WIDTH-1:0] acc, nxt, p;
   logic [WIDTH-1:0] bq, ao, aa, ab, r, lo_f, hi_f;
   logic [CNTW-1:0] cnt;
   logic nq, nr, ge, bz, dv;
   logic [WIDTH:0] sum, rr;
   mdu_signfix #(.W(WIDTH)) u_absa (.x(a), .neg(op[0] & a[WIDTH-1]), .y(aa));
   mdu_signfix #(.W(WIDTH)) u_absb (.x(b), .neg(op[0] & b[WIDTH-1]), .y(ab));
   // low half of the negated accumulator doubles as the negated quotient
   mdu_signfix #(.W(2*WIDTH)) u_fixp (.x(acc), .neg(nq), .y(p));
   mdu_signfix #(.W(WIDTH)) u_fixr (.x(acc[2*WIDTH-1:WIDTH]), .neg(nr), .y(r));
   always_comb begin
      dv   = is_div(opr);
      bz   = bq == '0;
      sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, bq};
      rr   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      ge   = rr >= {1'b0, bq};
      nxt  = dv ? {ge ? rr[WIDTH-1:0] - bq : rr[WIDTH-1:0], acc[WIDTH-2:0], ge}
                : acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
      lo_f = (dv && bz) ? '0 : p[WIDTH-1:0];
      hi_f = dv ? (bz ? ao : r) : p[2*WIDTH-1:WIDTH];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         st       <= IDLE;
         opr      <= MDU_UMULL;
         acc      <= '0;
         bq       <= '0;
         ao       <= '0;
         cnt      <= '0;
         nq       <= 1'b0;
         nr       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         res_lo   <= '0;
         res_hi   <= '0;
         div_zero <= 1'b0;
         flags    <= 2'b00;
      end else begin
         done <= 1'b0;
         if (st == IDLE || st == DONE) begin
            if (start && !kill) begin
               opr  <= op_t'(op);
               acc  <= {{WIDTH{1'b0}}, aa};
               bq   <= ab;
               ao   <= a;
               nq   <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
               nr   <= op[0] & a[WIDTH-1];
               cnt  <= '0;
               st   <= CALC;
               busy <= 1'b1;
            end else
               st <= IDLE;
         end else if (kill) begin
            st   <= IDLE;
            busy <= 1'b0;
         end else if (st == CALC) begin
            acc <= nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNTW'(WIDTH - 1)) st <= FIX;
         end else begin
            res_lo   <= lo_f;
            res_hi   <= hi_f;
            div_zero <= dv & bz;
            flags    <= dv ? {lo_f[WIDTH-1], lo_f == '0} : {hi_f[WIDTH-1], {hi_f, lo_f} == '0};
            st       <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and random checks of mdu_iter against an arithmetic reference model
module tb_mdu_iter;
   logic clk = 0, reset = 1, start = 0, kill = 0;
   logic [1:0] op = 0;
   logic [31:0] a = 0, b = 0;
   logic busy, done, div_zero;
   logic [31:0] res_lo, res_hi;
   logic [1:0] flags;
   int checks = 0, errors = 0;

   mdu_iter #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .kill(kill), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .res_lo(res_lo), .res_hi(res_hi), .div_zero(div_zero), .flags(flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [1:0] o, input logic [31:0] x, y,
                        output logic [31:0] lo, hi, output logic dz, output logic [1:0] fl);
      logic [63:0] pr;
      longint sx, sy, q, rm;
      dz = 0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (o[1] == 1'b0) begin
         pr = o[0] ? 64'(sx * sy) : {32'b0, x} * {32'b0, y};
         lo = pr[31:0];
         hi = pr[63:32];
         fl = {hi[31], pr == 0};
      end else begin
         if (y == 0) begin
            lo = 0; hi = x; dz = 1;
         end else if (o[0]) begin
            q = sx / sy; rm = sx % sy;
            lo = q[31:0]; hi = rm[31:0];
         end else begin
            lo = x / y; hi = x % y;
         end
         fl = {lo[31], lo == 0};
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] x, y, input int gl);
      logic [31:0] el, eh;
      logic ed;
      logic [1:0] ef;
      int bad;
      model(o, x, y, el, eh, ed, ef);
      op = o; a = x; b = y; start = 1;
      @(posedge clk); #1;
      start = 0; op = 2'($urandom); a = $urandom; b = $urandom;
      bad = 0;
      for (int k = 1; k <= 33; k++) begin
         start = (k == gl);
         if (busy !== 1'b1 || done !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      start = 0;
      chk("busy_window", 64'(bad), 0);
      chk("done_pulse", 64'(done), 1);
      chk("busy_at_done", 64'(busy), 0);
      chk("res_lo", 64'(res_lo), 64'(el));
      chk("res_hi", 64'(res_hi), 64'(eh));
      chk("div_zero", 64'(div_zero), 64'(ed));
      chk("flags", 64'(flags), 64'(ef));
   endtask

   initial begin
      logic [31:0] slo, shi;
      int bad;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_res", {res_hi, res_lo}, 0);
      chk("rst_dz_flags", {61'(0), div_zero, flags}, 0);
      reset = 0;
      @(posedge clk); #1;
      run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      chk("umull_const", {res_hi, res_lo}, 64'hFFFFFFFE_00000001);
      chk("umull_nz", 64'(flags), 2'b10);
      run_op(2'b01, -32'sd3, 32'd5, 0);
      run_op(2'b00, 32'd0, 32'd7, 0);
      chk("zero_z", 64'(flags), 2'b01);
      run_op(2'b10, 32'd100, 32'd7, 0);
      chk("udiv_const", {res_hi, res_lo}, {32'd2, 32'd14});
      run_op(2'b11, -32'sd7, 32'd2, 0);
      run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0);
      run_op(2'b10, 32'h1234, 32'd0, 0);
      run_op(2'b11, 32'hFFFFFF00, 32'd0, 0);
      run_op(2'b00, 32'd12345, 32'd678, 0);
      run_op(2'b11, 32'hDEADBEEF, 32'h00001234, 10);
      @(posedge clk); #1;
      chk("done_one_cycle", 64'(done), 0);
      run_op(2'b01, 32'h7FFFFFFF, 32'h80000000, 0);
      slo = res_lo; shi = res_hi;
      op = 2'b10; a = 32'd999; b = 32'd3; start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (4) @(posedge clk);
      #1;
      kill = 1;
      @(posedge clk); #1;
      kill = 0;
      chk("kill_busy", 64'(busy), 0);
      bad = 0;
      repeat (40) begin
         if (done !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      chk("kill_no_done", 64'(bad), 0);
      chk("kill_hold", {res_hi, res_lo}, {shi, slo});
      kill = 1; op = 2'b00; a = 5; b = 5; start = 1;
      @(posedge clk); #1;
      kill = 0; start = 0;
      chk("kill_blocks_start", 64'(busy), 0);
      op = 2'b11; a = 32'hFFFF0000; b = 32'd77; start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (11) @(posedge clk);
      #1;
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      chk("mid_rst_bd", {62'(0), busy, done}, 0);
      chk("mid_rst_res", {res_hi, res_lo}, 0);
      chk("mid_rst_dz_flags", {61'(0), div_zero, flags}, 0);
      run_op(2'b11, 32'hFFFF0000, 32'd77, 0);
      for (int i = 0; i < 24; i++) begin
         logic [31:0] rb;
         rb = (i % 6 == 5) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         run_op(2'($urandom), $urandom, rb, (i % 4 == 0) ? int'($urandom_range(1, 33)) : 0);
         if (i % 5 == 0) repeat (2) @(posedge clk);
         if (i % 5 == 0) #1;
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative, parametrised multiply/divide unit for the multi-cycle processor.
- Replaces the single-cycle long-multiply path: ALU high word into the second register-file write port.
- Adds unsigned/signed long multiply and unsigned/signed divide behind a start/busy/done handshake with the control FSM.
- Operands come from the SrcA/SrcB muxes. res_lo/res_hi feed the Result path and the second register write port.

Parameters:
- WIDTH, 32, operand width in bits. Must be ≥4. Results are WIDTH bits each (lo, hi).
- CNTW, $clog2(WIDTH+1), iteration counter width. Derived; not to be overridden.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the unit can accept
- kill  input  1  abort the current operation; no done is produced
- op  input  2  00 UMULL, 01 SMULL, 10 UDIV, 11 SDIV; captured with start
- a  input  WIDTH  multiplicand / dividend; captured with start
- b  input  WIDTH  multiplier / divisor; captured with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: results valid
- res_lo  output  WIDTH  multiply: low word; divide: quotient
- res_hi  output  WIDTH  multiply: high word; divide: remainder
- div_zero  output  1  last divide had b==0; valid with done, then held
- flags  output  2  {N,Z} of the last result; valid with done, then held

Behaviour:
- One clock; reset is synchronous and active-high.
  - Reset has priority over everything, including mid-operation.
  - Reset forces state IDLE, busy=0, done=0, res_lo=0, res_hi=0, div_zero=0, flags=0.
- States: IDLE, CALC, FIX, DONE.
- start is accepted in IDLE or DONE when kill=0. Acceptance edge = cycle 0.
  - On acceptance: latch op, take |a| and |b| (signed ops only), record result sign(s), clear counter.
  - Go to CALC.
- start while in CALC or FIX is ignored; latched operands are unaffected.
- CALC runs exactly WIDTH cycles (cycles 1..WIDTH), one bit per cycle.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient shifts into lo, partial remainder in hi.
- FIX runs one cycle (cycle WIDTH+1).
  - SMULL: negate the 2*WIDTH product if the operand signs differ.
  - SDIV: negate the quotient if the signs differ; remainder takes the sign of the dividend.
  - Load res_lo, res_hi, flags and div_zero.
- DONE (cycle WIDTH+2): done=1 for exactly one cycle, busy=0.
  - Returns to IDLE next cycle unless a new start is accepted (back-to-back allowed).
- busy=1 in CALC and FIX only.
- Fixed latency: done occurs WIDTH+2 cycles after the acceptance edge for all ops, including divide by zero.
- res_lo, res_hi, flags and div_zero hold their values from FIX until the next FIX or reset.
- Divide by zero (b==0): res_lo=0, res_hi=a (original, unsigned view), div_zero=1.
  - The CALC cycles are still consumed.
  - div_zero=0 for all other ops.
- SDIV with a=min (1 followed by WIDTH-1 zeros), b=-1: res_lo=min, res_hi=0. No trap.
- flags:
  - Multiply: N = res_hi[WIDTH-1], Z = ({res_hi,res_lo}==0).
  - Divide: N = res_lo[WIDTH-1], Z = (res_lo==0).
- kill in CALC or FIX: next state IDLE, busy=0, no done, results/flags unchanged.
  - kill in IDLE or DONE: blocks acceptance of a same-cycle start; otherwise no effect.
- All arithmetic is unsigned internally at WIDTH+1 bits for the subtract. Negation is two's complement at the full width of the field.

Decomposition:
- Shared package mdu_pkg:
  - op encodings: MDU_UMULL, MDU_SMULL, MDU_UDIV, MDU_SDIV.
  - FSM state encoding.
  - Helpers is_signed(op) and is_div(op).
- Sub-module mdu_signfix: combinational conditional two's-complement negate.
  - Parametrised width.
  - Used for abs() at capture and for result correction in FIX (WIDTH and 2*WIDTH instances).
- FSM, counter and datapath registers stay in mdu_iter.

Test Plan:
- UMULL a=0xFFFFFFFF b=0xFFFFFFFF, start at cycle 0 -> busy cycles 1..33, done only at cycle 34, res_hi=0xFFFFFFFE, res_lo=0x00000001, flags N=1 Z=0.
- SMULL a=-3 b=5 -> res_hi=0xFFFFFFFF, res_lo=0xFFFFFFF1, N=1. Then UMULL a=0 b=7 issued on the done cycle -> accepted back-to-back; Z=1 at its done.
- UDIV 100/7 -> res_lo=14, res_hi=2. SDIV -7/2 -> res_lo=0xFFFFFFFD, res_hi=0xFFFFFFFF. SDIV 0x80000000/0xFFFFFFFF -> res_lo=0x80000000, res_hi=0.
- UDIV a=0x1234 b=0 -> done at cycle 34, res_lo=0, res_hi=0x1234, div_zero=1. Next UMULL -> div_zero=0.
- start pulsed with new operands at cycle 10 of a busy op -> ignored, original result returned. kill at cycle 5 -> busy=0 at cycle 6, no done, previous results held.
- reset asserted at cycle 12 of an SDIV -> next cycle all outputs 0, state IDLE. A start after reset deasserts completes normally with correct result.
